// File: rtl/spi_master_tx_if.sv
// SPI master bundle: host-side request/response handshake plus the four SPI wires.
// The master modport is the controller's view; the slave modport is the host/peer view.
interface spi_master_tx_if #(
  parameter int DATA_W = 16
);
  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;
  logic              SCK;
  logic              MOSI;
  logic              MISO;
  logic              SSEL;

  modport master (
    input  start,
    input  tx_data,
    input  MISO,
    output busy,
    output done,
    output rx_data,
    output SCK,
    output MOSI,
    output SSEL
  );

  modport slave (
    output start,
    output tx_data,
    output MISO,
    input  busy,
    input  done,
    input  rx_data,
    input  SCK,
    input  MOSI,
    input  SSEL
  );
endinterface

// File: rtl/spi_master_tx.sv
// SPI mode-0 master: one DATA_W-bit frame per request, MSB first, full duplex.
// All SPI pins come straight from flops so the board link never sees decode glitches.
module spi_master_tx #(
  parameter int DATA_W   = 16,
  parameter int CLK_DIV  = 25,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_IDLE  = 8
) (
  input  logic            clk50M,
  input  logic            rst,
  spi_master_tx_if.master bus
);

  localparam int DIV_W    = $clog2(CLK_DIV);
  localparam int CNT_W    = $clog2(DATA_W + 1);
  localparam int WAIT_MAX = (CS_SETUP > CS_HOLD)
                            ? ((CS_SETUP > CS_IDLE) ? CS_SETUP : CS_IDLE)
                            : ((CS_HOLD  > CS_IDLE) ? CS_HOLD  : CS_IDLE);
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    HOLD  = 3'd4,
    DONE  = 3'd5,
    GAP   = 3'd6
  } state_t;

  state_t              state;
  state_t              state_nxt;

  logic [DIV_W-1:0]    div_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [CNT_W-1:0]    bit_cnt;
  logic [DATA_W-1:0]   tx_sh;
  logic [DATA_W-1:0]   tx_sh_nxt;
  logic [DATA_W-1:0]   rx_sh;
  logic [DATA_W-1:0]   rx_data_q;

  logic                sck_q;
  logic                mosi_q;
  logic                ssel_q;
  logic                busy_q;
  logic                done_q;

  logic                sck_d;
  logic                mosi_d;
  logic                ssel_d;
  logic                busy_d;
  logic                done_d;

  logic                div_last;
  logic                setup_last;
  logic                hold_last;
  logic                gap_last;
  logic                sck_rise;
  logic                sck_fall;
  logic                accept;

  // Phase terminal counts; GAP is one short because DONE already holds SSEL high.
  assign div_last   = (div_cnt  == DIV_W'(CLK_DIV - 1));
  assign setup_last = (wait_cnt == WAIT_W'(CS_SETUP - 1));
  assign hold_last  = (wait_cnt == WAIT_W'(CS_HOLD - 1));
  assign gap_last   = (wait_cnt == WAIT_W'(CS_IDLE - 2));

  assign accept     = (state == IDLE) && bus.start;
  assign sck_rise   = (state == LOW)  && (state_nxt == HIGH);
  assign sck_fall   = (state == HIGH) && (state_nxt == LOW);

  // State register together with the state-decoded pin flops
  always_ff @(posedge clk50M) begin
    if (rst) begin
      state  <= IDLE;
      sck_q  <= 1'b0;
      mosi_q <= 1'b0;
      ssel_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      sck_q  <= sck_d;
      mosi_q <= mosi_d;
      ssel_q <= ssel_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start)  state_nxt = SETUP;
      SETUP:   if (setup_last) state_nxt = LOW;
      LOW:     if (div_last)   state_nxt = HIGH;
      HIGH: begin
        if (div_last) begin
          state_nxt = (bit_cnt == CNT_W'(DATA_W)) ? HOLD : LOW;
        end
      end
      HOLD:    if (hold_last)  state_nxt = DONE;
      DONE:                    state_nxt = GAP;
      GAP:     if (gap_last)   state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so the pin flops line up with it
  always_comb begin
    sck_d  = 1'b0;
    mosi_d = 1'b0;
    ssel_d = 1'b1;
    busy_d = 1'b1;
    done_d = 1'b0;
    case (state_nxt)
      IDLE: busy_d = 1'b0;
      SETUP, LOW: begin
        ssel_d = 1'b0;
        mosi_d = tx_sh_nxt[DATA_W-1];
      end
      HIGH: begin
        ssel_d = 1'b0;
        sck_d  = 1'b1;
        mosi_d = tx_sh_nxt[DATA_W-1];
      end
      HOLD:    ssel_d = 1'b0;
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    tx_sh_nxt = tx_sh;
    if (accept) begin
      tx_sh_nxt = bus.tx_data;
    end else if (sck_fall) begin
      tx_sh_nxt = {tx_sh[DATA_W-2:0], 1'b0};
    end
  end

  // Counters restart on every state change and stay parked outside their phases
  always_ff @(posedge clk50M) begin
    if (rst) begin
      div_cnt   <= '0;
      wait_cnt  <= '0;
      bit_cnt   <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      rx_data_q <= '0;
    end else begin
      if ((state_nxt != state) || !((state == LOW) || (state == HIGH))) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      if ((state_nxt != state) ||
          !((state == SETUP) || (state == HOLD) || (state == GAP))) begin
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      if (state == IDLE) begin
        bit_cnt <= '0;
      end else if (sck_rise) begin
        bit_cnt <= bit_cnt + 1'b1;
      end

      tx_sh <= tx_sh_nxt;

      if (sck_rise) begin
        rx_sh <= {rx_sh[DATA_W-2:0], bus.MISO};
      end

      if (state_nxt == DONE) begin
        rx_data_q <= rx_sh;
      end
    end
  end

  assign bus.SCK     = sck_q;
  assign bus.MOSI    = mosi_q;
  assign bus.SSEL    = ssel_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: frame-timeline model checked every cycle, plus directed frames
// with hand-computed literal expectations.
module tb_spi_master_tx;

  localparam int DATA_W   = 16;
  localparam int CLK_DIV  = 25;
  localparam int CS_SETUP = 4;
  localparam int CS_HOLD  = 4;
  localparam int CS_IDLE  = 8;

  // Frame timeline, in cycles after the accept cycle
  localparam int T_RUN   = 2 * CLK_DIV * DATA_W;
  localparam int K_FIRST = 1 + CS_SETUP;
  localparam int K_DONE  = 1 + CS_SETUP + T_RUN + CS_HOLD;
  localparam int K_IDLE  = K_DONE + CS_IDLE;

  logic clk50M = 1'b0;
  logic rst    = 1'b1;
  logic loop_en    = 1'b0;
  logic miso_const = 1'b0;

  always #10 clk50M = ~clk50M;

  spi_master_tx_if #(.DATA_W(DATA_W)) bus ();

  assign bus.MISO = loop_en ? bus.MOSI : miso_const;

  spi_master_tx #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV),
    .CS_SETUP(CS_SETUP),
    .CS_HOLD (CS_HOLD),
    .CS_IDLE (CS_IDLE)
  ) dut (
    .clk50M(clk50M),
    .rst   (rst),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: which cycle the current frame was accepted in, and what it must deliver
  int              cyc      = 0;
  bit              in_frame = 1'b0;
  int              acc_p    = 0;
  logic [DATA_W-1:0] acc_d  = '0;
  logic            acc_loop = 1'b0;
  logic            acc_mc   = 1'b0;
  logic [DATA_W-1:0] exp_rx = '0;

  always @(posedge clk50M) begin
    if (rst) begin
      in_frame = 1'b0;
      exp_rx   = '0;
    end else begin
      if ((!in_frame || (cyc - acc_p >= K_IDLE)) && bus.start) begin
        in_frame = 1'b1;
        acc_p    = cyc;
        acc_d    = bus.tx_data;
        acc_loop = loop_en;
        acc_mc   = miso_const;
      end
      if (in_frame && (cyc + 1 - acc_p == K_DONE))
        exp_rx = acc_loop ? acc_d : {DATA_W{acc_mc}};
    end
    cyc++;
  end

  // Per-cycle comparison plus observation counters used by the directed checks
  bit              chk_en      = 1'b0;
  int              k, bidx;
  logic            e_busy, e_done, e_ssel, e_sck;
  logic            prev_sck    = 1'b0;
  logic            prev_ssel   = 1'b1;
  int              rise_cnt    = 0;
  int              done_cnt    = 0;
  int              done_cyc    = 0;
  int              mosi_hi_cnt = 0;
  int              ssel_run    = 0;
  int              last_run    = 0;
  logic [DATA_W-1:0] mosi_cap  = '0;

  always @(negedge clk50M) begin
    if (chk_en) begin
      k      = cyc - acc_p;
      e_busy = in_frame && (k >= 1) && (k < K_IDLE);
      e_done = in_frame && (k == K_DONE);
      e_ssel = !(in_frame && (k >= 1) && (k < K_DONE));
      e_sck  = in_frame && (k >= K_FIRST) && (k < K_FIRST + T_RUN) &&
               ((((k - K_FIRST) / CLK_DIV) % 2) == 1);
      chk("busy", 32'(bus.busy), 32'(e_busy));
      chk("done", 32'(bus.done), 32'(e_done));
      chk("ssel", 32'(bus.SSEL), 32'(e_ssel));
      chk("sck",  32'(bus.SCK),  32'(e_sck));
      chk("rx_data", 32'(bus.rx_data), 32'(exp_rx));
      if (in_frame && (k >= 1) && (k < K_FIRST + T_RUN)) begin
        bidx = (k < K_FIRST) ? 0 : (k - K_FIRST) / (2 * CLK_DIV);
        chk("mosi", 32'(bus.MOSI), 32'(acc_d[DATA_W-1-bidx]));
      end else if (!in_frame) begin
        chk("mosi_idle", 32'(bus.MOSI), 32'd0);
      end
    end
    if (bus.SCK && !prev_sck) begin
      rise_cnt++;
      mosi_cap = {mosi_cap[DATA_W-2:0], bus.MOSI};
    end
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (!bus.SSEL && bus.MOSI) mosi_hi_cnt++;
    if (bus.SSEL) begin
      ssel_run++;
    end else begin
      if (prev_ssel) last_run = ssel_run;
      ssel_run = 0;
    end
    prev_sck  = bus.SCK;
    prev_ssel = bus.SSEL;
  end

  // mode 0: plain frame; 1: stray start after the 5th SCK rise; 2: start held over DONE+GAP
  task automatic run_frame(input logic [DATA_W-1:0] d, input logic lp, input logic mc,
                           input int mode, input logic [DATA_W-1:0] want_rx,
                           input logic [DATA_W-1:0] want_mosi, input string tag);
    int  sp, r0, d0, h0;
    bit  got, pulsed;
    loop_en    = lp;
    miso_const = mc;
    @(negedge clk50M); #1;
    sp = cyc; r0 = rise_cnt; d0 = done_cnt; h0 = mosi_hi_cnt;
    bus.start   = 1'b1;
    bus.tx_data = d;
    got = 1'b0; pulsed = 1'b0;
    for (int n = 0; n < 2000 && !got; n++) begin
      @(negedge clk50M); #1;
      if (n == 0) bus.tx_data = ~d;
      if (mode == 1 && !pulsed && (rise_cnt - r0 == 5)) begin
        bus.start   = 1'b1;
        bus.tx_data = '1;
        pulsed      = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (done_cnt != d0) got = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    chk({tag, "_latency"}, 32'(done_cyc - sp), 32'd809);
    chk({tag, "_sck_rises"}, 32'(rise_cnt - r0), 32'd16);
    chk({tag, "_mosi_bits"}, 32'(mosi_cap), 32'(want_mosi));
    chk({tag, "_rx_data"}, 32'(bus.rx_data), 32'(want_rx));
    if (mode == 2) begin
      bus.start = 1'b1;
      repeat (8) begin @(negedge clk50M); #1; end
      bus.start = 1'b0;
      chk({tag, "_busy_after_gap"}, 32'(bus.busy), 32'd0);
    end
    if (mode != 0) begin
      repeat (900) @(negedge clk50M);
      #1;
      chk({tag, "_single_done"}, 32'(done_cnt - d0), 32'd1);
    end else begin
      got = 1'b0;
      for (int n = 0; n < 50 && !got; n++) begin
        @(negedge clk50M); #1;
        if (!bus.busy) got = 1'b1;
      end
      chk({tag, "_busy_drop"}, 32'(got), 32'd1);
    end
    if (tag == "zero_miso1")
      chk({tag, "_mosi_high"}, 32'(mosi_hi_cnt - h0), 32'd0);
  endtask

  initial begin
    int r0, d0;
    bit got;
    bus.start   = 1'b0;
    bus.tx_data = '0;

    repeat (3) @(posedge clk50M);
    @(negedge clk50M); #1;
    chk("rst_ssel", 32'(bus.SSEL), 32'd1);
    chk("rst_sck",  32'(bus.SCK),  32'd0);
    chk("rst_mosi", 32'(bus.MOSI), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_rx",   32'(bus.rx_data), 32'd0);
    rst    = 1'b0;
    chk_en = 1'b1;

    r0 = rise_cnt;
    repeat (1000) @(negedge clk50M);
    #1;
    chk("idle_sck_rises", 32'(rise_cnt - r0), 32'd0);
    chk("idle_ssel", 32'(bus.SSEL), 32'd1);

    run_frame(16'hA5C3, 1'b1, 1'b0, 0, 16'hA5C3, 16'hA5C3, "loop_a5c3");
    run_frame(16'h0000, 1'b0, 1'b1, 0, 16'hFFFF, 16'h0000, "zero_miso1");
    run_frame(16'h0000, 1'b0, 1'b0, 0, 16'h0000, 16'h0000, "zero_miso0");

    // Reset mid-frame, right after the 7th SCK rise
    loop_en = 1'b1;
    @(negedge clk50M); #1;
    r0 = rise_cnt; d0 = done_cnt;
    bus.start   = 1'b1;
    bus.tx_data = 16'h3C3C;
    got = 1'b0;
    for (int n = 0; n < 2000 && !got; n++) begin
      @(negedge clk50M); #1;
      bus.start = 1'b0;
      if (rise_cnt - r0 == 7) got = 1'b1;
    end
    chk("midrst_seventh_rise", 32'(got), 32'd1);
    rst = 1'b1;
    @(negedge clk50M); #1;
    rst = 1'b0;
    chk("midrst_ssel", 32'(bus.SSEL), 32'd1);
    chk("midrst_sck",  32'(bus.SCK),  32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_rx",   32'(bus.rx_data), 32'd0);
    repeat (900) @(negedge clk50M);
    #1;
    chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);

    run_frame(16'h1234, 1'b1, 1'b0, 1, 16'h1234, 16'h1234, "busy_start");
    run_frame(16'h5A96, 1'b1, 1'b0, 2, 16'h5A96, 16'h5A96, "gap_start");
    run_frame(16'hC001, 1'b1, 1'b0, 0, 16'hC001, 16'hC001, "after_gap");
    chk("ssel_gap_ge8", 32'(last_run >= 8), 32'd1);

    repeat (5) @(negedge clk50M);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
